neokeon_rotl32_by5_fun: RTL and testbench
=========================================

Name: neokeon_rotl32_by5_fun

Overview:
- Neokeon datapath helper: rotates a 32-bit word left by a fixed 5 bits (ROTL5), as used in the Pi1/Pi2 layers of the Neokeon-128 round.
- Two result paths:
  - combinational `outputData`, for chaining inside round logic;
  - registered, valid-tagged `outDataReg`, for pipelined round implementations.
- Sits beside the other Neokeon word-level permutation blocks, between the Gamma and Pi stages.

Parameters:
- WIDTH, 32, word width in bits; must be ≥ 2.
- SHIFT, 5, left-rotate amount; legal range 0..WIDTH-1; SHIFT=0 is identity.

Ports:
- inClk  input  1  single system clock; rising edge active.
- inRst  input  1  asynchronous, active-high reset.
- inDataWord  input  WIDTH  word to rotate.
- inValid  input  1  qualifies `inDataWord` for the registered path.
- outputData  output  WIDTH  combinational ROTL(`inDataWord`, SHIFT).
- outDataReg  output  WIDTH  registered ROTL result.
- outValid  output  1  high when `outDataReg` holds a freshly captured result.

Behaviour:
- Rotation definition:
  - `outputData[(i+SHIFT) mod WIDTH] = inDataWord[i]` for all i.
  - Equivalently, for WIDTH=32 and SHIFT=5: `{inDataWord[26:0], inDataWord[31:27]}`.
  - No bits are lost; pure wiring, no arithmetic.
- Combinational path:
  - `outputData` follows `inDataWord` with zero cycle latency.
  - Independent of `inClk`, `inRst` and `inValid`.
  - Valid even while reset is asserted.
- Registered path, on each rising `inClk` edge with `inRst` low:
  - `inValid`=1: `outDataReg` ← ROTL(`inDataWord`, SHIFT); `outValid` ← 1.
  - `inValid`=0: `outDataReg` holds its value; `outValid` ← 0.
- Latency and throughput:
  - Registered path has exactly 1 cycle of latency.
  - Accepts a new word every cycle; no backpressure and no ready signal.
- Reset:
  - On `inRst` assertion, `outDataReg` goes to 0 and `outValid` to 0 immediately, without waiting for a clock edge.
  - Reset asserted mid-operation discards any in-flight word.
  - First capture is possible on the first rising edge after `inRst` deasserts.
- Simultaneous `inRst`=1 and `inValid`=1: reset wins; nothing is captured.
- X-free requirement: every output is driven at all times; no latches.
- Elaboration check: SHIFT ≥ WIDTH is an error (fatal assertion).

Decomposition:
- Shared package `neokeon_pkg`:
  - constant NK_WORD_W = 32;
  - rotate constants NK_ROT_PI1_A = 1, NK_ROT_PI1_B = 5, NK_ROT_PI2_A = 31, NK_ROT_PI2_B = 30;
  - typedef `nk_word_t` (logic [31:0]);
  - function `nk_rotl(word, amt)`.
- One natural sub-module: `nk_rotl_comb`, the parameterised pure-wire rotator.
  - The top instantiates it once and feeds both the combinational output and the pipeline register.

Test Plan:
- Combinational, no clock dependence:
  - `inDataWord`=0x00800080 → `outputData`=0x10001000 within the same delta.
  - 0x12345678 → 0x468ACF02.
- Wrap-around:
  - 0xF8000000 → 0x0000001F.
  - 0x80000001 → 0x00000030.
  - 0xFFFFFFFF → 0xFFFFFFFF.
  - 0x00000000 → 0x00000000.
- Registered path: `inValid`=1 with 0x00800080 at edge N → `outDataReg`=0x10001000 and `outValid`=1 after edge N; `inValid`=0 at edge N+1 → `outValid`=0 and `outDataReg` held at 0x10001000.
- Async reset: assert `inRst` between edges while `outDataReg`=0x10001000 → `outDataReg`=0 and `outValid`=0 before the next edge; `outputData` still tracks its input.
- Streaming: 1000 random words with `inValid`=1 every cycle → `outDataReg` at cycle k+1 equals the reference `nk_rotl(word_k, 5)`; zero mismatches.
- Parameter sweep: WIDTH=32, SHIFT ∈ {0, 1, 31} with 0x00000001 → 0x00000001, 0x00000002 and 0x80000000 respectively.

Source files
------------

// File: rtl/neokeon_pkg.sv
// Shared Neokeon word-level definitions: word width, Pi-layer rotate amounts,
// word type and a reference rotate helper for software-style use in round logic.
package neokeon_pkg;

  localparam int NK_WORD_W = 32;

  // Rotate amounts used by the Pi1 / Pi2 permutation layers
  localparam int NK_ROT_PI1_A = 1;
  localparam int NK_ROT_PI1_B = 5;
  localparam int NK_ROT_PI2_A = 31;
  localparam int NK_ROT_PI2_B = 30;

  typedef logic [NK_WORD_W-1:0] nk_word_t;

  // Rotate left by amt (taken modulo the word width); the upper half of the
  // doubled word after shifting is exactly the rotated word.
  function automatic nk_word_t nk_rotl(input nk_word_t word, input int unsigned amt);
    logic [2*NK_WORD_W-1:0] w_dbl;
    w_dbl = {word, word} << (amt % NK_WORD_W);
    return w_dbl[2*NK_WORD_W-1:NK_WORD_W];
  endfunction

endpackage

// File: rtl/nk_rotl_comb.sv
// Parameterised pure-wire left rotator: o_word = ROTL(i_word, SHIFT).
// Zero latency, no clock, no backpressure.
module nk_rotl_comb
  import neokeon_pkg::*;
#(
  parameter int WIDTH = NK_WORD_W,
  parameter int SHIFT = NK_ROT_PI1_B
) (
  input  logic [WIDTH-1:0] i_word,
  output logic [WIDTH-1:0] o_word
);

  // Each input bit lands SHIFT places higher, wrapping at the top
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign o_word[(i + SHIFT) % WIDTH] = i_word[i];
  end

endmodule

// File: rtl/neokeon_rotl32_by5_fun.sv
// Neokeon ROTL helper: combinational rotate plus a 1-cycle registered, valid-tagged copy.
// Accepts a word every cycle; no backpressure; async active-high reset clears the register.
module neokeon_rotl32_by5_fun
  import neokeon_pkg::*;
#(
  parameter int WIDTH = NK_WORD_W,
  parameter int SHIFT = NK_ROT_PI1_B
) (
  input  logic             inClk,
  input  logic             inRst,
  input  logic [WIDTH-1:0] inDataWord,
  input  logic             inValid,
  output logic [WIDTH-1:0] outputData,
  output logic [WIDTH-1:0] outDataReg,
  output logic             outValid
);

  if (WIDTH < 2) begin : g_bad_width
    $fatal(1, "neokeon_rotl32_by5_fun: WIDTH must be >= 2");
  end
  if ((SHIFT < 0) || (SHIFT >= WIDTH)) begin : g_bad_shift
    $fatal(1, "neokeon_rotl32_by5_fun: SHIFT must lie in 0..WIDTH-1");
  end

  logic [WIDTH-1:0] w_rot;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  nk_rotl_comb #(
    .WIDTH (WIDTH),
    .SHIFT (SHIFT)
  ) u_rotl (
    .i_word (inDataWord),
    .o_word (w_rot)
  );

  // Data holds when idle; valid is a one-cycle strobe per captured word
  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= inValid;
      if (inValid) begin
        r_data <= w_rot;
      end
    end
  end

  assign outputData = w_rot;
  assign outDataReg = r_data;
  assign outValid   = r_valid;

endmodule

// File: tb/tb_neokeon_rotl32_by5_fun.sv
// Self-checking bench for neokeon_rotl32_by5_fun: directed vectors, async reset,
// random streaming against a bit-placement reference, and a SHIFT sweep.
module tb_neokeon_rotl32_by5_fun;

  logic        inClk = 1'b0;
  logic        inRst;
  logic [31:0] inDataWord;
  logic        inValid;
  logic [31:0] outputData;
  logic [31:0] outDataReg;
  logic        outValid;

  logic [31:0] sw_data;
  logic [31:0] s0_comb, s1_comb, s31_comb;
  logic [31:0] s0_reg, s1_reg, s31_reg;
  logic        s0_vld, s1_vld, s31_vld;

  int errors = 0;
  int checks = 0;

  always #5 inClk = ~inClk;

  neokeon_rotl32_by5_fun dut (
    .inClk      (inClk),
    .inRst      (inRst),
    .inDataWord (inDataWord),
    .inValid    (inValid),
    .outputData (outputData),
    .outDataReg (outDataReg),
    .outValid   (outValid)
  );

  neokeon_rotl32_by5_fun #(.WIDTH(32), .SHIFT(0)) u_s0 (
    .inClk(inClk), .inRst(inRst), .inDataWord(sw_data), .inValid(inValid),
    .outputData(s0_comb), .outDataReg(s0_reg), .outValid(s0_vld));
  neokeon_rotl32_by5_fun #(.WIDTH(32), .SHIFT(1)) u_s1 (
    .inClk(inClk), .inRst(inRst), .inDataWord(sw_data), .inValid(inValid),
    .outputData(s1_comb), .outDataReg(s1_reg), .outValid(s1_vld));
  neokeon_rotl32_by5_fun #(.WIDTH(32), .SHIFT(31)) u_s31 (
    .inClk(inClk), .inRst(inRst), .inDataWord(sw_data), .inValid(inValid),
    .outputData(s31_comb), .outDataReg(s31_reg), .outValid(s31_vld));

  // Reference: bit i of the input moves to position (i+s) mod 32
  function automatic logic [31:0] ref_rotl(input logic [31:0] w, input int s);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[(i + s) % 32] = w[i];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge inClk);
    #1;
  endtask

  logic [31:0] vec_in  [6];
  logic [31:0] vec_out [6];
  logic [31:0] held;
  logic [31:0] w;

  initial begin
    vec_in[0] = 32'h00800080; vec_out[0] = 32'h10001000;
    vec_in[1] = 32'h12345678; vec_out[1] = 32'h468ACF02;
    vec_in[2] = 32'hF8000000; vec_out[2] = 32'h0000001F;
    vec_in[3] = 32'h80000001; vec_out[3] = 32'h00000030;
    vec_in[4] = 32'hFFFFFFFF; vec_out[4] = 32'hFFFFFFFF;
    vec_in[5] = 32'h00000000; vec_out[5] = 32'h00000000;

    inRst = 1'b1;
    inValid = 1'b0;
    inDataWord = 32'h0;
    sw_data = 32'h0;
    #1;
    check("reset_reg", outDataReg, 32'h0);
    check("reset_vld", {31'b0, outValid}, 32'h0);

    // Combinational path works during reset, with known constants and the model
    for (int i = 0; i < 6; i++) begin
      inDataWord = vec_in[i];
      #1;
      check("comb_vec", outputData, vec_out[i]);
      check("comb_model", outputData, ref_rotl(vec_in[i], 5));
    end

    // Reset held with inValid=1 across an edge: nothing captured
    inDataWord = 32'h00800080;
    inValid = 1'b1;
    tick();
    check("rst_wins_reg", outDataReg, 32'h0);
    check("rst_wins_vld", {31'b0, outValid}, 32'h0);

    // Release reset between edges; first capture on the very next edge
    inRst = 1'b0;
    inValid = 1'b1;
    inDataWord = 32'h00800080;
    tick();
    check("cap_reg", outDataReg, 32'h10001000);
    check("cap_vld", {31'b0, outValid}, 32'h1);

    inValid = 1'b0;
    inDataWord = 32'hDEADBEEF;
    tick();
    check("idle_vld", {31'b0, outValid}, 32'h0);
    check("idle_hold", outDataReg, 32'h10001000);
    check("idle_comb", outputData, ref_rotl(32'hDEADBEEF, 5));

    // Async reset mid-cycle clears the register before any edge
    #2;
    inRst = 1'b1;
    #1;
    check("arst_reg", outDataReg, 32'h0);
    check("arst_vld", {31'b0, outValid}, 32'h0);
    inDataWord = 32'h12345678;
    #1;
    check("arst_comb", outputData, 32'h468ACF02);
    tick();
    inRst = 1'b0;

    // Streaming: a new word every cycle
    for (int k = 0; k < 1000; k++) begin
      w = $urandom;
      inDataWord = w;
      inValid = 1'b1;
      tick();
      check("stream_reg", outDataReg, ref_rotl(w, 5));
      check("stream_vld", {31'b0, outValid}, 32'h1);
    end

    // Random valid gaps: register holds the last captured word
    held = outDataReg;
    for (int k = 0; k < 200; k++) begin
      w = $urandom;
      inDataWord = w;
      inValid = ($urandom_range(0, 2) != 0);
      if (inValid) held = ref_rotl(w, 5);
      tick();
      check("gap_reg", outDataReg, held);
      check("gap_vld", {31'b0, outValid}, {31'b0, inValid});
    end

    // SHIFT sweep on parallel instances
    inValid = 1'b0;
    sw_data = 32'h00000001;
    #1;
    check("sweep_s0", s0_comb, 32'h00000001);
    check("sweep_s1", s1_comb, 32'h00000002);
    check("sweep_s31", s31_comb, 32'h80000000);
    for (int k = 0; k < 20; k++) begin
      w = $urandom;
      sw_data = w;
      inValid = 1'b1;
      tick();
      check("sweep_s0_reg", s0_reg, ref_rotl(w, 0));
      check("sweep_s1_reg", s1_reg, ref_rotl(w, 1));
      check("sweep_s31_reg", s31_reg, ref_rotl(w, 31));
      check("sweep_vld", {29'b0, s0_vld, s1_vld, s31_vld}, 32'h7);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
